lcd_bus_monitor: RTL and testbench
==================================

# lcd_bus_monitor

Passive receiver for the HD44780-style parallel LCD bus (RS, EN, 8-bit data) that the solar-tracker top drives to its character display. It samples the bus on the system clock and decodes each EN-strobed transfer as a command or a data write. It keeps a 2x16 shadow of the visible display RAM and flags bus-timing violations. It sits beside the display driver as a self-check and simulation observer: the bench or debug logic reads back what the panel would show without a physical LCD.

## Interface
Parameters:
- MIN_EN_HIGH, 4: minimum EN high width in CLK cycles; shorter pulses are rejected.
- MIN_GAP, 4000: minimum CLK cycles from one accepted EN falling edge to the next EN rising edge.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock (pll_clk domain).
- RST  in  1  asynchronous, active-high reset.
- RS  in  1  register select; 0 = command, 1 = data.
- EN  in  1  bus enable; a transfer completes on its falling edge.
- DATA  in  8  bus data.
- RD_ADDR  in  5  shadow read index; bit 4 = line, bits 3:0 = column.
- CLR_ERR  in  1  synchronous clear of sticky error flags.
- RD_CHAR  out  8  registered shadow content at RD_ADDR.
- WR_STB  out  1  one-cycle pulse when a character is stored.
- WR_ADDR  out  5  index written by the last WR_STB.
- CMD_STB  out  1  one-cycle pulse when a command is decoded.
- CMD  out  8  last decoded command byte.
- CURSOR  out  5  current address counter.
- DISP_ON  out  1  display-on bit from the last display-control command.
- BUSY  out  1  high while the clear fill is running.
- ERR_PULSE  out  1  sticky: EN high width was below MIN_EN_HIGH.
- ERR_GAP  out  1  sticky: transfer started too early or during BUSY.

## Operation
- EN, RS and DATA pass through 2-flop synchronizers. RS and DATA are delay-matched to EN and latched at the synchronized EN falling edge.
- FSM states:
  - IDLE: on synchronized EN rising edge, go to HIGH.
  - HIGH: count EN-high cycles. On the falling edge, go to DECODE if count >= MIN_EN_HIGH; otherwise set ERR_PULSE and return to IDLE.
  - DECODE: one cycle. Go to CLEAR if the command is 0x01; otherwise go to IDLE.
  - CLEAR: write 0x20 to indices 0..31, one per cycle (32 cycles, BUSY=1), then go to IDLE.
- Gap counter:
  - Restarts at every accepted falling edge and saturates at MIN_GAP.
  - An EN rising edge with the counter below MIN_GAP sets ERR_GAP, but the transfer is still decoded.
  - An EN rising edge while BUSY sets ERR_GAP and the whole transfer is ignored.
- Command decode, by highest set bit:
  - 0x00: no-op, but CMD_STB still pulses.
  - 0x01 clear: fill with spaces, CURSOR=0, ID=1, mode=DDRAM.
  - 0x02-0x03 home: CURSOR=0.
  - 0x04-0x07 entry mode: ID=DATA[1].
  - 0x08-0x0F display control: DISP_ON=DATA[2].
  - 0x10-0x1F: if DATA[3]=0, CURSOR +1 when DATA[2]=1, else -1. Display shift is ignored.
  - 0x20-0x3F function set: no state change.
  - 0x40-0x7F: mode=CGRAM.
  - 0x80-0xFF: mode=DDRAM, CURSOR={DATA[6],DATA[3:0]}.
- Data write (RS=1):
  - In DDRAM mode: store DATA at CURSOR, WR_ADDR=CURSOR, pulse WR_STB, then CURSOR +1 if ID=1, else -1.
  - In CGRAM mode: discard the byte, no WR_STB, CURSOR unchanged.
- CURSOR arithmetic is 5-bit modulo: 31+1=0 (line 2 col 15 wraps to line 1 col 0), 0-1=31.
- CLR_ERR clears both error flags. If an error occurs in the same cycle as CLR_ERR, the flag is set.

## Timing
- Reset values:
  - RD_CHAR=0x20, WR_STB=0, WR_ADDR=0, CMD_STB=0, CMD=0x00, CURSOR=0, DISP_ON=0, BUSY=0, ERR_*=0.
  - Shadow = all 0x20, ID=1, mode=DDRAM, FSM=IDLE, gap counter saturated (first transfer is never a gap error).
- Let k be the first CLK edge that samples EN=0 after a high pulse. WR_STB or CMD_STB is high for exactly the cycle following edge k+3.
  - CURSOR, CMD, DISP_ON and the shadow update on that same edge.
- BUSY rises with CMD_STB for a clear and stays high 32 cycles. Shadow entry i holds 0x20 from cycle i+1 of the fill.
- RD_CHAR has 1-cycle latency from RD_ADDR and reflects a write on the cycle after WR_STB.
- A reset asserted mid-transfer or mid-clear returns all state to reset values immediately. An EN low at reset release is not an edge.

## Test plan
Bench override: MIN_EN_HIGH=4, MIN_GAP=16.
- After reset, send cmd 0x80 then data 0x41,0x42 (EN 6 cycles, gap 20) -> CMD_STB once; WR_STB at WR_ADDR 0 then 1; RD_ADDR 1 gives 0x42; CURSOR=2; no errors.
- Cmd 0xCF, data 0x5A, data 0x5B -> 0x5A at index 31, 0x5B at index 0 (wrap); CURSOR=1.
- Cmd 0x04 (decrement), cmd 0x80, data 0x33 -> 0x33 at index 0; CURSOR=31.
- Cmd 0x01, then data 0x44 launched 5 cycles later -> BUSY 32 cycles; ERR_GAP=1; 0x44 not stored; all 32 entries read 0x20.
- EN high 2 cycles with data 0x55 -> ERR_PULSE=1, no strobe; CLR_ERR pulse -> ERR_PULSE=0.
- Cmd 0x40, data 0x1F, cmd 0x0C -> no WR_STB for 0x1F; DISP_ON=1; reset during a 6-cycle EN pulse -> no strobe and all outputs at reset values.

Source files
------------

// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor
//   Passive observer of an HD44780-style parallel LCD bus. Decodes each
//   EN-strobed transfer as a command or a data write. Keeps a 2x16 shadow of
//   the visible display RAM and flags EN width / spacing violations.
//
// Ports
//   CLK, RST        system clock, async active-high reset
//   RS, EN, DATA    raw LCD bus (asynchronous to CLK)
//   RD_ADDR         shadow read index {line, column[3:0]}
//   CLR_ERR         synchronous clear of the sticky error flags
//   RD_CHAR         registered shadow byte at RD_ADDR
//   WR_STB/WR_ADDR  character-stored pulse and its index
//   CMD_STB/CMD     command-decoded pulse and last command byte
//   CURSOR          address counter
//   DISP_ON         display-on bit
//   BUSY            clear fill in progress
//   ERR_PULSE       sticky: EN high shorter than MIN_EN_HIGH
//   ERR_GAP         sticky: transfer started too early or while BUSY
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a synchronized EN rising edge
// S_HIGH   | counting EN-high cycles until the falling edge
// S_DECODE | one cycle: apply the latched command / data byte
// S_CLEAR  | writing spaces into all 32 shadow entries, BUSY high

module lcd_bus_monitor #(
   parameter int MIN_EN_HIGH = 4,
   parameter int MIN_GAP     = 4000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RS,
   input  logic       EN,
   input  logic [7:0] DATA,
   input  logic [4:0] RD_ADDR,
   input  logic       CLR_ERR,
   output logic [7:0] RD_CHAR,
   output logic       WR_STB,
   output logic [4:0] WR_ADDR,
   output logic       CMD_STB,
   output logic [7:0] CMD,
   output logic [4:0] CURSOR,
   output logic       DISP_ON,
   output logic       BUSY,
   output logic       ERR_PULSE,
   output logic       ERR_GAP
);

   localparam int HW = $clog2(MIN_EN_HIGH + 1);
   localparam int GW = $clog2(MIN_GAP + 1);
   localparam logic [HW-1:0] HI_MIN  = HW'(MIN_EN_HIGH);
   localparam logic [GW-1:0] GAP_MIN = GW'(MIN_GAP);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_DECODE, S_CLEAR} state_t;
   state_t state, state_nxt;

   logic          en_s1, en_s2, en_d, rs_s1, rs_s2;
   logic [7:0]    data_s1, data_s2;
   logic          en_rise, en_fall;
   logic [HW-1:0] hi_cnt;
   logic [GW-1:0] gap_cnt;
   logic [4:0]    fill_idx;
   logic          rs_lat;
   logic [7:0]    dat_lat;
   logic          id_inc, cgram;
   logic [7:0]    shadow [32];
   logic          accept, short_pulse, gap_err, start, is_clear;

   // RS/DATA take the same two-flop path as EN so they stay aligned with it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         en_s1   <= 1'b0;
         en_s2   <= 1'b0;
         en_d    <= 1'b0;
         rs_s1   <= 1'b0;
         rs_s2   <= 1'b0;
         data_s1 <= '0;
         data_s2 <= '0;
      end else begin
         en_s1   <= EN;
         en_s2   <= en_s1;
         en_d    <= en_s2;
         rs_s1   <= RS;
         rs_s2   <= rs_s1;
         data_s1 <= DATA;
         data_s2 <= data_s1;
      end
   end

   assign en_rise  = en_s2 & ~en_d;
   assign en_fall  = ~en_s2 & en_d;
   assign is_clear = ~rs_lat & (dat_lat == 8'h01);
   assign BUSY     = (state == S_CLEAR);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start       = 1'b0;
      accept      = 1'b0;
      short_pulse = 1'b0;
      gap_err     = 1'b0;
      case (state)
         S_IDLE: begin
            if (en_rise) begin
               state_nxt = S_HIGH;
               start     = 1'b1;
               gap_err   = (gap_cnt < GAP_MIN);
            end
         end
         S_HIGH: begin
            if (en_fall) begin
               if (hi_cnt >= HI_MIN) begin
                  state_nxt = S_DECODE;
                  accept    = 1'b1;
               end else begin
                  state_nxt   = S_IDLE;
                  short_pulse = 1'b1;
               end
            end
         end
         S_DECODE: begin
            state_nxt = is_clear ? S_CLEAR : S_IDLE;
            // A rise here is always early; if a clear follows, the bus is
            // about to be busy and the transfer is dropped.
            if (en_rise) begin
               gap_err = (gap_cnt < GAP_MIN) | is_clear;
               if (!is_clear) begin
                  state_nxt = S_HIGH;
                  start     = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            gap_err = en_rise;
            if (fill_idx == 5'd31) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hi_cnt    <= '0;
         gap_cnt   <= GAP_MIN;
         fill_idx  <= '0;
         rs_lat    <= 1'b0;
         dat_lat   <= '0;
         id_inc    <= 1'b1;
         cgram     <= 1'b0;
         for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
         RD_CHAR   <= 8'h20;
         WR_STB    <= 1'b0;
         WR_ADDR   <= '0;
         CMD_STB   <= 1'b0;
         CMD       <= '0;
         CURSOR    <= '0;
         DISP_ON   <= 1'b0;
         ERR_PULSE <= 1'b0;
         ERR_GAP   <= 1'b0;
      end else begin
         WR_STB    <= 1'b0;
         CMD_STB   <= 1'b0;
         RD_CHAR   <= shadow[RD_ADDR];
         // A new error wins over a simultaneous clear.
         ERR_PULSE <= short_pulse | (ERR_PULSE & ~CLR_ERR);
         ERR_GAP   <= gap_err | (ERR_GAP & ~CLR_ERR);

         if (start)
            hi_cnt <= HW'(1);
         else if (state == S_HIGH && en_s2 && hi_cnt < HI_MIN)
            hi_cnt <= hi_cnt + 1'b1;

         if (accept) begin
            gap_cnt <= '0;
            rs_lat  <= rs_s2;
            dat_lat <= data_s2;
         end else if (gap_cnt < GAP_MIN) begin
            gap_cnt <= gap_cnt + 1'b1;
         end

         if (state == S_DECODE) begin
            if (rs_lat) begin
               if (!cgram) begin
                  shadow[CURSOR] <= dat_lat;
                  WR_ADDR        <= CURSOR;
                  WR_STB         <= 1'b1;
                  CURSOR         <= id_inc ? CURSOR + 5'd1 : CURSOR - 5'd1;
               end
            end else begin
               CMD_STB <= 1'b1;
               CMD     <= dat_lat;
               casez (dat_lat)
                  8'b1???????: begin
                     cgram  <= 1'b0;
                     CURSOR <= {dat_lat[6], dat_lat[3:0]};
                  end
                  8'b01??????: cgram <= 1'b1;
                  8'b001?????: begin end
                  8'b0001????: begin
                     if (!dat_lat[3])
                        CURSOR <= dat_lat[2] ? CURSOR + 5'd1 : CURSOR - 5'd1;
                  end
                  8'b00001???: DISP_ON <= dat_lat[2];
                  8'b000001??: id_inc  <= dat_lat[1];
                  8'b0000001?: CURSOR  <= '0;
                  8'b00000001: begin
                     CURSOR <= '0;
                     id_inc <= 1'b1;
                     cgram  <= 1'b0;
                  end
                  default: begin end
               endcase
            end
         end

         if (state == S_CLEAR) begin
            shadow[fill_idx] <= 8'h20;
            fill_idx         <= fill_idx + 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
`timescale 1ns/1ps
module tb_lcd_bus_monitor;

   localparam int MIN_EN_HIGH = 4;
   localparam int MIN_GAP     = 16;

   logic       CLK = 1'b0;
   logic       RST, RS, EN, CLR_ERR;
   logic [7:0] DATA;
   logic [4:0] RD_ADDR;
   logic [7:0] RD_CHAR, CMD;
   logic       WR_STB, CMD_STB, DISP_ON, BUSY, ERR_PULSE, ERR_GAP;
   logic [4:0] WR_ADDR, CURSOR;

   lcd_bus_monitor #(.MIN_EN_HIGH(MIN_EN_HIGH), .MIN_GAP(MIN_GAP)) dut (
      .CLK(CLK), .RST(RST), .RS(RS), .EN(EN), .DATA(DATA), .RD_ADDR(RD_ADDR),
      .CLR_ERR(CLR_ERR), .RD_CHAR(RD_CHAR), .WR_STB(WR_STB), .WR_ADDR(WR_ADDR),
      .CMD_STB(CMD_STB), .CMD(CMD), .CURSOR(CURSOR), .DISP_ON(DISP_ON),
      .BUSY(BUSY), .ERR_PULSE(ERR_PULSE), .ERR_GAP(ERR_GAP)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int fall_cyc = 0;

   // bus monitor
   int wr_seen = 0, cmd_seen = 0, busy_cyc = 0, last_wa = 0, last_stb_cyc = 0;
   always @(posedge CLK) cyc++;
   always @(negedge CLK) begin
      if (WR_STB)  begin wr_seen++;  last_wa = int'(WR_ADDR); last_stb_cyc = cyc; end
      if (CMD_STB) begin cmd_seen++; last_stb_cyc = cyc; end
      if (BUSY) busy_cyc++;
   end

   // reference model of what the panel should hold
   logic [7:0] m_ram [32];
   int         m_cur, m_wa, m_wr, m_cmdn;
   bit         m_id, m_cg, m_disp;
   logic [7:0] m_cmd;

   function automatic void m_reset();
      for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
      m_cur = 0; m_wa = 0; m_id = 1; m_cg = 0; m_disp = 0; m_cmd = 8'h00;
   endfunction

   function automatic void m_xfer(input bit rs, input logic [7:0] d);
      if (rs) begin
         if (!m_cg) begin
            m_ram[m_cur] = d;
            m_wa  = m_cur;
            m_wr++;
            m_cur = m_id ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
         end
      end else begin
         m_cmdn++;
         m_cmd = d;
         if (d >= 8'h80) begin
            m_cg  = 0;
            m_cur = (d[6] ? 16 : 0) + int'(d) % 16;
         end else if (d >= 8'h40) m_cg = 1;
         else if (d >= 8'h20) begin end
         else if (d >= 8'h10) begin
            if (!d[3]) m_cur = d[2] ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
         end else if (d >= 8'h08) m_disp = d[2];
         else if (d >= 8'h04) m_id = d[1];
         else if (d >= 8'h02) m_cur = 0;
         else if (d == 8'h01) begin
            m_cur = 0; m_id = 1; m_cg = 0;
            for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input bit rs, input logic [7:0] d, input int width, input int gap);
      @(posedge CLK); #1;
      RS = rs; DATA = d; EN = 1'b1;
      repeat (width) @(posedge CLK);
      #1 EN = 1'b0;
      fall_cyc = cyc;
      repeat (3) @(posedge CLK);
      #1 DATA = 8'($urandom); RS = 1'($urandom);
      if (gap > 3) repeat (gap - 3) @(posedge CLK);
   endtask

   task automatic rd(input logic [4:0] a, output logic [7:0] v);
      @(negedge CLK); RD_ADDR = a;
      @(negedge CLK); v = RD_CHAR;
   endtask

   task automatic clr_err();
      @(posedge CLK); #1 CLR_ERR = 1'b1;
      @(posedge CLK); #1 CLR_ERR = 1'b0;
      @(negedge CLK);
   endtask

   task automatic chk_state(input string tag);
      @(negedge CLK);
      chk({tag, "_cursor"}, CURSOR, m_cur);
      chk({tag, "_wr_cnt"}, wr_seen, m_wr);
      chk({tag, "_cmd_cnt"}, cmd_seen, m_cmdn);
      chk({tag, "_disp"}, DISP_ON, m_disp);
      chk({tag, "_cmd"}, CMD, m_cmd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [7:0] v;
   bit         r_rs;
   logic [7:0] r_d;
   int         r_w, r_g, b0, w0, c0;

   initial begin
      RST = 1'b1; RS = 1'b0; EN = 1'b0; DATA = 8'h00; RD_ADDR = 5'd0; CLR_ERR = 1'b0;
      m_wr = 0; m_cmdn = 0;
      m_reset();
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_rd_char", RD_CHAR, 8'h20);
      chk("rst_wr_stb", WR_STB, 0);
      chk("rst_cmd_stb", CMD_STB, 0);
      chk("rst_cursor", CURSOR, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_errs", {ERR_PULSE, ERR_GAP}, 0);

      // set DDRAM address 0, write "AB"
      xfer(0, 8'h80, 6, 20); m_xfer(0, 8'h80);
      chk("cmd_latency", last_stb_cyc - fall_cyc, 4);
      xfer(1, 8'h41, 6, 20); m_xfer(1, 8'h41);
      chk("wr_latency", last_stb_cyc - fall_cyc, 4);
      chk("wr_addr0", last_wa, 0);
      xfer(1, 8'h42, 6, 20); m_xfer(1, 8'h42);
      chk("wr_addr1", last_wa, 1);
      chk_state("t1");
      chk("t1_cursor_abs", CURSOR, 2);
      rd(5'd1, v); chk("t1_rd1", v, 8'h42);
      chk("t1_errs", {ERR_PULSE, ERR_GAP}, 0);

      // wrap from index 31 to 0
      xfer(0, 8'hCF, 6, 20); m_xfer(0, 8'hCF);
      xfer(1, 8'h5A, 6, 20); m_xfer(1, 8'h5A);
      chk("t2_wa31", last_wa, 31);
      xfer(1, 8'h5B, 6, 20); m_xfer(1, 8'h5B);
      chk("t2_wa0", last_wa, 0);
      chk_state("t2");
      chk("t2_cursor_abs", CURSOR, 1);
      rd(5'd31, v); chk("t2_rd31", v, 8'h5A);
      rd(5'd0, v);  chk("t2_rd0", v, 8'h5B);

      // decrement mode, wrap below 0
      xfer(0, 8'h04, 6, 20); m_xfer(0, 8'h04);
      xfer(0, 8'h80, 6, 20); m_xfer(0, 8'h80);
      xfer(1, 8'h33, 6, 20); m_xfer(1, 8'h33);
      chk_state("t3");
      chk("t3_cursor_abs", CURSOR, 31);
      rd(5'd0, v); chk("t3_rd0", v, 8'h33);

      // clear, with a data write launched while BUSY
      b0 = busy_cyc;
      xfer(0, 8'h01, 6, 5); m_xfer(0, 8'h01);
      xfer(1, 8'h44, 6, 60);
      chk("t4_busy_len", busy_cyc - b0, 32);
      chk("t4_err_gap", ERR_GAP, 1);
      chk_state("t4");
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), v);
         chk($sformatf("t4_space%0d", i), v, 8'h20);
      end

      // short EN pulse
      w0 = wr_seen;
      xfer(1, 8'h55, 2, 20);
      @(negedge CLK);
      chk("t5_err_pulse", ERR_PULSE, 1);
      chk("t5_no_wr", wr_seen, w0);
      clr_err();
      chk("t5_errs_cleared", {ERR_PULSE, ERR_GAP}, 0);

      // CGRAM data discarded, display on (minimum-width pulse)
      xfer(0, 8'h40, 6, 20); m_xfer(0, 8'h40);
      xfer(1, 8'h1F, 6, 20); m_xfer(1, 8'h1F);
      xfer(0, 8'h0C, MIN_EN_HIGH, 20); m_xfer(0, 8'h0C);
      chk_state("t6");
      chk("t6_disp_abs", DISP_ON, 1);

      // random transfers against the model
      for (int i = 0; i < 40; i++) begin
         r_rs = 1'($urandom_range(0, 1));
         r_d  = 8'($urandom_range(0, 255));
         r_w  = $urandom_range(2, 8);
         r_g  = (!r_rs && r_d == 8'h01) ? 45 : 20;
         xfer(r_rs, r_d, r_w, r_g);
         if (r_w >= MIN_EN_HIGH) m_xfer(r_rs, r_d);
         chk_state($sformatf("rnd%0d", i));
         chk($sformatf("rnd%0d_err_pulse", i), ERR_PULSE, (r_w < MIN_EN_HIGH) ? 1 : 0);
         chk($sformatf("rnd%0d_err_gap", i), ERR_GAP, 0);
         if (ERR_PULSE) clr_err();
      end
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), v);
         chk($sformatf("rnd_ram%0d", i), v, m_ram[i]);
      end

      // reset in the middle of a 6-cycle pulse
      w0 = wr_seen; c0 = cmd_seen;
      @(posedge CLK); #1 RS = 1'b1; DATA = 8'h61; EN = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 EN = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      m_reset();
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      chk("rr_no_wr", wr_seen, w0);
      chk("rr_no_cmd", cmd_seen, c0);
      chk("rr_cursor", CURSOR, 0);
      chk("rr_cmd", CMD, 0);
      chk("rr_disp", DISP_ON, 0);
      chk("rr_wr_addr", WR_ADDR, 0);
      chk("rr_flags", {WR_STB, CMD_STB, BUSY, ERR_PULSE, ERR_GAP}, 0);
      rd(5'd0, v); chk("rr_rd0", v, 8'h20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
